// File: rtl/regstrb2mem.sv
// regstrb2mem: assembles 64-bit BPF instructions from two 32-bit register
// strobes and writes them to sequential code-memory addresses.
// Optional macro REGSTRB2MEM_OVERFLOW_GUARD_EN: adds code_mem_full and
// stops the write pointer at the last address instead of wrapping.
module regstrb2mem #(
  parameter int CODE_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [CODE_ADDR_WIDTH-1:0] code_mem_wr_addr,
  output logic [63:0]                code_mem_wr_data,
  output logic                       code_mem_wr_en,
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
  output logic                       code_mem_full,
`endif
  input  logic [31:0]                inst_high_value,
  input  logic                       inst_high_strobe,
  input  logic [31:0]                inst_low_value,
  input  logic                       inst_low_strobe,
  input  logic                       control_start
);

  localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_ONE  = CODE_ADDR_WIDTH'(1);
  localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic [31:0]                hi_q, hi_d;
  logic [CODE_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CODE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]                data_q, data_d;
  logic                       wr_q, wr_d;
  logic [CODE_ADDR_WIDTH-1:0] base_ptr;
  logic                       full_q, full_d;

  // Next-state: high-half bypass, commit decision and pointer advance.
  always_comb begin
    hi_d     = inst_high_strobe ? inst_high_value : hi_q;
    // A start in the same cycle as a commit redirects that commit to 0.
    base_ptr = control_start ? '0 : ptr_q;
    ptr_d    = base_ptr;
    full_d   = control_start ? 1'b0 : full_q;
    addr_d   = addr_q;
    data_d   = data_q;
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
    wr_d     = inst_low_strobe && !full_d;
`else
    wr_d     = inst_low_strobe;
`endif
    if (wr_d) begin
      addr_d = base_ptr;
      data_d = {hi_d, inst_low_value};
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
      // Park on the last address once it has been written.
      if (base_ptr == ADDR_LAST) full_d = 1'b1;
      else                       ptr_d  = base_ptr + ADDR_ONE;
`else
      ptr_d  = base_ptr + ADDR_ONE;
`endif
    end
  end

  // State and output registers; reset clears everything including the data word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      ptr_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      full_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
      full_q <= full_d;
`else
      full_q <= 1'b0;
`endif
    end
  end

  assign code_mem_wr_addr = addr_q;
  assign code_mem_wr_data = data_q;
  assign code_mem_wr_en   = wr_q;
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
  assign code_mem_full    = full_q;
`endif

endmodule

// File: tb/tb_regstrb2mem.sv
// Testbench for regstrb2mem: behavioural model plus per-cycle compare,
// directed scenarios with literal expectations, and random stimulus.
module tb_regstrb2mem;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] code_mem_wr_addr;
  logic [63:0]   code_mem_wr_data;
  logic          code_mem_wr_en;
  logic          code_mem_full;
  logic [31:0]   inst_high_value;
  logic          inst_high_strobe;
  logic [31:0]   inst_low_value;
  logic          inst_low_strobe;
  logic          control_start;

  int checks = 0;
  int fails  = 0;

  regstrb2mem #(.CODE_ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .code_mem_wr_addr (code_mem_wr_addr),
    .code_mem_wr_data (code_mem_wr_data),
    .code_mem_wr_en   (code_mem_wr_en),
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
    .code_mem_full    (code_mem_full),
`endif
    .inst_high_value  (inst_high_value),
    .inst_high_strobe (inst_high_strobe),
    .inst_low_value   (inst_low_value),
    .inst_low_strobe  (inst_low_strobe),
    .control_start    (control_start)
  );

`ifndef REGSTRB2MEM_OVERFLOW_GUARD_EN
  assign code_mem_full = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: instruction counter since last start, modular or saturating.
  logic          started = 1'b0;
  logic          exp_en  = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [63:0]   exp_data = '0;
  logic          exp_full = 1'b0;
  logic [31:0]   m_hi = '0;
  int            m_count = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      started  = 1'b1;
      exp_en   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_full = 1'b0;
      m_hi     = '0;
      m_count  = 0;
    end else begin
      if (inst_high_strobe) m_hi = inst_high_value;
      if (control_start) m_count = 0;
      exp_en = 1'b0;
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
      if (inst_low_strobe && m_count < DEPTH) begin
`else
      if (inst_low_strobe) begin
`endif
        exp_en   = 1'b1;
        exp_addr = AW'(m_count % DEPTH);
        exp_data = {m_hi, inst_low_value};
        m_count  = m_count + 1;
      end
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
      exp_full = (m_count >= DEPTH);
`endif
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (started) begin
      chk("wr_en", 64'(code_mem_wr_en), 64'(exp_en));
      chk("wr_addr", 64'(code_mem_wr_addr), 64'(exp_addr));
      chk("wr_data", code_mem_wr_data, exp_data);
      chk("full", 64'(code_mem_full), 64'(exp_full));
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic drive(input logic hs, input logic [31:0] hv,
                       input logic ls, input logic [31:0] lv, input logic cs);
    inst_high_strobe = hs;
    inst_high_value  = hv;
    inst_low_strobe  = ls;
    inst_low_value   = lv;
    control_start    = cs;
    @(posedge clk);
    #1;
    inst_high_strobe = 1'b0;
    inst_low_strobe  = 1'b0;
    control_start    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_write(input string name, input logic [AW-1:0] a, input logic [63:0] d);
    chk({name, "_en"}, 64'(code_mem_wr_en), 64'd1);
    chk({name, "_addr"}, 64'(code_mem_wr_addr), 64'(a));
    chk({name, "_data"}, code_mem_wr_data, d);
  endtask

  logic [31:0] pat_hi [3] = '{32'h11111111, 32'h33333333, 32'h55555555};
  logic [31:0] pat_lo [3] = '{32'h22222222, 32'h44444444, 32'h66666666};

  initial begin
    rst_n = 1'b0;
    inst_high_strobe = 1'b0; inst_high_value = '0;
    inst_low_strobe  = 1'b0; inst_low_value  = '0;
    control_start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    chk("reset_en", 64'(code_mem_wr_en), 64'd0);
    chk("reset_addr", 64'(code_mem_wr_addr), 64'd0);
    chk("reset_data", code_mem_wr_data, 64'd0);

    // Single instruction.
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b1, 32'h00000028, 1'b0, '0, 1'b0);
    chk("no_write_on_high", 64'(code_mem_wr_en), 64'd0);
    drive(1'b0, '0, 1'b1, 32'h0000000C, 1'b0);
    expect_write("single", AW'(0), 64'h000000280000000C);
    idle(1);
    chk("single_en_drop", 64'(code_mem_wr_en), 64'd0);

    // Three pairs at addresses 0..2 (restart first).
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pat_hi[i], 1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b1, pat_lo[i], 1'b0);
      expect_write("pair", AW'(i), {pat_hi[i], pat_lo[i]});
    end

    // Simultaneous strobe bypass, then the latch persists.
    drive(1'b1, 32'hDEADBEEF, 1'b1, 32'h00000001, 1'b0);
    expect_write("bypass", AW'(3), 64'hDEADBEEF00000001);
    drive(1'b0, '0, 1'b1, 32'h00000002, 1'b0);
    expect_write("latched", AW'(4), 64'hDEADBEEF00000002);

    // Restart after five writes; start alone writes nothing.
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk("start_no_write", 64'(code_mem_wr_en), 64'd0);
    drive(1'b1, 32'hA5A5A5A5, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h00000007, 1'b0);
    expect_write("restart", AW'(0), 64'hA5A5A5A500000007);
    drive(1'b0, '0, 1'b1, 32'h00000008, 1'b1);
    expect_write("start_low", AW'(0), 64'hA5A5A5A500000008);
    drive(1'b0, '0, 1'b1, 32'h00000009, 1'b0);
    expect_write("after_start_low", AW'(1), 64'hA5A5A5A500000009);

    // Random traffic, checked by the per-cycle compare.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 0, $urandom,
            $urandom_range(0, 40) == 0);

    // Boundary: fill the whole memory.
    drive(1'b1, 32'hCAFEF00D, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 32'(i), 1'b0);
    expect_write("last", AW'(DEPTH - 1), {32'hCAFEF00D, 32'(DEPTH - 1)});
    drive(1'b0, '0, 1'b1, 32'h0000BEEF, 1'b0);
`ifdef REGSTRB2MEM_OVERFLOW_GUARD_EN
    chk("overflow_en", 64'(code_mem_wr_en), 64'd0);
    chk("overflow_full", 64'(code_mem_full), 64'd1);
    drive(1'b0, '0, 1'b1, 32'h0000BEF0, 1'b0);
    chk("overflow_drop", 64'(code_mem_wr_en), 64'd0);
    drive(1'b0, '0, 1'b1, 32'h00000055, 1'b1);
    expect_write("full_restart", AW'(0), {32'hCAFEF00D, 32'h00000055});
    chk("full_cleared", 64'(code_mem_full), 64'd0);
`else
    expect_write("wrap", AW'(0), {32'hCAFEF00D, 32'h0000BEEF});
    drive(1'b0, '0, 1'b1, 32'h0000BEF0, 1'b0);
    expect_write("wrap_next", AW'(1), {32'hCAFEF00D, 32'h0000BEF0});
`endif
    // Random again, including cycles while full (guard build).
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 0, $urandom,
            $urandom_range(0, 60) == 0);

    // Reset in the middle of a strobe overrides it.
    rst_n = 1'b0;
    drive(1'b1, 32'h12345678, 1'b1, 32'h9ABCDEF0, 1'b0);
    rst_n = 1'b1;
    chk("rst_override_en", 64'(code_mem_wr_en), 64'd0);
    chk("rst_override_data", code_mem_wr_data, 64'd0);
    drive(1'b0, '0, 1'b1, 32'h00000003, 1'b0);
    expect_write("post_reset", AW'(0), 64'h0000000000000003);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regstrb2mem.md
Name: regstrb2mem

Overview:
- Bridges the CPU-visible instruction registers (inst_high, inst_low, control start) to the BPF code memory write port.
- Assembles a 64-bit instruction from two 32-bit register strobes.
- Writes each assembled instruction to sequential code-memory addresses, starting from 0 at each control_start.
- Sits between the AXI/register front end and the code memory.

Parameters:
- CODE_ADDR_WIDTH, 10, width of the code-memory address and of the internal write pointer (depth 2^CODE_ADDR_WIDTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- code_mem_wr_addr  output  CODE_ADDR_WIDTH  code-memory write address.
- code_mem_wr_data  output  64  instruction word, {high[31:0], low[31:0]}.
- code_mem_wr_en  output  1  one-cycle write enable.
- inst_high_value  input  32  upper instruction half.
- inst_high_strobe  input  1  one-cycle pulse: inst_high_value is valid.
- inst_low_value  input  32  lower instruction half.
- inst_low_strobe  input  1  one-cycle pulse: inst_low_value is valid; commits the instruction.
- control_start  input  1  pulse: restart loading at address 0.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - code_mem_wr_en=0, code_mem_wr_addr=0, code_mem_wr_data=0.
  - high-half latch=0, write pointer=0.
  - Reset overrides all strobes in that cycle.
- High half:
  - On inst_high_strobe=1, latch inst_high_value into the high-half register.
  - The latch holds until the next high strobe; it is not cleared by a low strobe or by control_start.
- Commit:
  - On inst_low_strobe=1 in cycle N, in cycle N+1 (1-cycle registered latency):
    - code_mem_wr_en=1.
    - code_mem_wr_addr = pointer value used for the commit.
    - code_mem_wr_data = {high, inst_low_value}.
  - The pointer increments by 1 at the same edge.
- code_mem_wr_en is high for exactly one cycle per low strobe.
  - Back-to-back low strobes give back-to-back writes at consecutive addresses.
- When code_mem_wr_en=0, addr and data hold their last values (don't-care to memory).
- Simultaneous high and low strobe in the same cycle: the committed word uses the new inst_high_value (bypass), and the latch is also updated.
- control_start=1: pointer set to 0.
  - If inst_low_strobe is also 1 that cycle, the write goes to address 0 and the pointer becomes 1.
  - control_start alone produces no write.
- Wrap-around (macro not defined): after writing address 2^CODE_ADDR_WIDTH-1, the pointer wraps to 0.
- No back-pressure: the memory accepts a write every cycle.
- Strobes are level-sampled each cycle. A strobe held high for k cycles is treated as k strobes.

Optional Feature:
- Macro REGSTRB2MEM_OVERFLOW_GUARD_EN.
- Defined:
  - Adds output code_mem_full (1 bit, reset 0).
  - After a write to the last address (1023 by default), code_mem_full=1 and the pointer stays at the last address.
  - Further low strobes produce no write (code_mem_wr_en stays 0) and are dropped.
  - control_start or reset clears code_mem_full and the pointer.
  - control_start plus low strobe in the same cycle while full: writes address 0 and clears full.
- Not defined: no code_mem_full port; the pointer wraps silently as above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> wr_en=0, addr=0, data=0 for all idle cycles.
- Single instruction: control_start; high strobe 0x00000028; next cycle low strobe 0x0000000C -> one cycle later wr_en=1, addr=0, data=0x000000280000000C; wr_en low afterward.
- Sequence: three (high, low) pairs (0x11111111/0x22222222, 0x33333333/0x44444444, 0x55555555/0x66666666) -> writes at addr 0,1,2 with matching 64-bit data, each exactly one cycle.
- Simultaneous high+low strobe: high 0xDEADBEEF, low 0x00000001 in the same cycle -> data 0xDEADBEEF00000001. Then a lone low 0x2 -> data 0xDEADBEEF00000002 at the next address.
- Restart: after 5 writes, pulse control_start, then one pair -> write at addr 0. Also control_start plus low strobe in the same cycle -> write at addr 0, next write at addr 1.
- Boundary:
  - 1024 consecutive low strobes -> addresses 0..1023 written.
  - 1025th strobe without the macro -> write at addr 0.
  - 1025th strobe with REGSTRB2MEM_OVERFLOW_GUARD_EN -> no write, code_mem_full=1; control_start clears it.
